// File: rtl/ghost_mode_scheduler.sv
// Global ghost mode sequencer: scatter/chase schedule, frightened timer with flashing, reversal strobe, eaten-ghost combo.
// Latency: every output is registered; an input event shows up on the next frame_clk edge.
// Backpressure: none; enable low freezes all state, forces strobes low and drops input events.
module ghost_mode_scheduler #(
    parameter int SCATTER_FRAMES      = 420,
    parameter int SCATTER_LATE_FRAMES = 300,
    parameter int CHASE_FRAMES        = 1200,
    parameter int FRIGHT_FRAMES       = 360,
    parameter int FLASH_FRAMES        = 120,
    parameter int FLASH_PERIOD        = 14
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic        enable,
    input  logic        power_pellet,
    input  logic        ghost_eaten,
    output logic [1:0]  mode,
    output logic [2:0]  phase,
    output logic        flash,
    output logic        reverse,
    output logic        score_valid,
    output logic [10:0] score_pts
);

    localparam int FW  = $clog2(FRIGHT_FRAMES + 1);
    localparam int FLW = $clog2(FLASH_PERIOD + 1);

    localparam logic [10:0]    SCAT_END    = 11'(SCATTER_FRAMES - 1);
    localparam logic [10:0]    LATE_END    = 11'(SCATTER_LATE_FRAMES - 1);
    localparam logic [10:0]    CHASE_END   = 11'(CHASE_FRAMES - 1);
    localparam logic [FW-1:0]  FRIGHT_LOAD = FW'(FRIGHT_FRAMES - 1);
    // Counter value at the edge that lands on FLASH_FRAMES-1, i.e. where flashing starts.
    localparam logic [FW-1:0]  FLASH_START = FW'(FLASH_FRAMES);
    localparam logic [FLW-1:0] PERIOD_END  = FLW'(FLASH_PERIOD - 1);

    localparam logic [1:0] MODE_FRIGHT = 2'b10;

    logic [10:0]    sched_cnt;
    logic [10:0]    sched_end;
    logic [FW-1:0]  fright_cnt;
    logic [FLW-1:0] flash_cnt;
    logic [1:0]     combo;
    logic           boundary;

    // Last count of the current phase; phase 7 never ends so its value is unused.
    always_comb begin
        sched_end = CHASE_END;
        case (phase)
            3'd0, 3'd2: sched_end = SCAT_END;
            3'd4, 3'd6: sched_end = LATE_END;
            default:    sched_end = CHASE_END;
        endcase
    end

    assign boundary = (phase != 3'd7) && (sched_cnt == sched_end);

    // Schedule, fright timer, flash and score state; later assignments take priority on collisions.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            mode        <= 2'b00;
            phase       <= 3'd0;
            flash       <= 1'b0;
            reverse     <= 1'b0;
            score_valid <= 1'b0;
            score_pts   <= 11'd0;
            sched_cnt   <= 11'd0;
            fright_cnt  <= '0;
            flash_cnt   <= '0;
            combo       <= 2'd0;
        end else if (!enable) begin
            reverse     <= 1'b0;
            score_valid <= 1'b0;
        end else begin
            reverse     <= 1'b0;
            score_valid <= 1'b0;

            // Score with the combo held before this edge; a pellet below may clear it afterwards.
            if (ghost_eaten && mode == MODE_FRIGHT) begin
                score_valid <= 1'b1;
                score_pts   <= 11'd200 << combo;
                if (combo != 2'd3) begin
                    combo <= combo + 2'd1;
                end
            end

            if (mode == MODE_FRIGHT) begin
                if (power_pellet) begin
                    // Re-trigger beats expiry and never reverses.
                    fright_cnt <= FRIGHT_LOAD;
                    combo      <= 2'd0;
                    flash      <= 1'b0;
                    flash_cnt  <= '0;
                end else if (fright_cnt == '0) begin
                    mode  <= {1'b0, phase[0]};
                    flash <= 1'b0;
                end else begin
                    fright_cnt <= fright_cnt - FW'(1);
                    if (fright_cnt == FLASH_START) begin
                        flash     <= 1'b1;
                        flash_cnt <= '0;
                    end else if (fright_cnt < FLASH_START) begin
                        if (flash_cnt == PERIOD_END) begin
                            flash     <= ~flash;
                            flash_cnt <= '0;
                        end else begin
                            flash_cnt <= flash_cnt + FLW'(1);
                        end
                    end
                end
            end else begin
                // The entry edge itself is still a schedule frame, so the schedule advances first.
                if (boundary) begin
                    phase     <= phase + 3'd1;
                    sched_cnt <= 11'd0;
                    reverse   <= 1'b1;
                    mode      <= {1'b0, ~phase[0]};
                end else if (phase != 3'd7) begin
                    sched_cnt <= sched_cnt + 11'd1;
                end
                if (power_pellet) begin
                    mode       <= MODE_FRIGHT;
                    fright_cnt <= FRIGHT_LOAD;
                    combo      <= 2'd0;
                    flash      <= 1'b0;
                    flash_cnt  <= '0;
                    reverse    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
module tb_ghost_mode_scheduler;

    localparam int SCAT   = 4;
    localparam int LATE   = 3;
    localparam int CHASE  = 6;
    localparam int FRIGHT = 8;
    localparam int FLASH  = 4;
    localparam int PERIOD = 2;

    logic        frame_clk = 1'b0;
    logic        Reset = 1'b0;
    logic        enable = 1'b0;
    logic        power_pellet = 1'b0;
    logic        ghost_eaten = 1'b0;
    logic [1:0]  mode;
    logic [2:0]  phase;
    logic        flash;
    logic        reverse;
    logic        score_valid;
    logic [10:0] score_pts;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    ghost_mode_scheduler #(
        .SCATTER_FRAMES(SCAT), .SCATTER_LATE_FRAMES(LATE), .CHASE_FRAMES(CHASE),
        .FRIGHT_FRAMES(FRIGHT), .FLASH_FRAMES(FLASH), .FLASH_PERIOD(PERIOD)
    ) dut (
        .frame_clk(frame_clk), .Reset(Reset), .enable(enable),
        .power_pellet(power_pellet), .ghost_eaten(ghost_eaten),
        .mode(mode), .phase(phase), .flash(flash), .reverse(reverse),
        .score_valid(score_valid), .score_pts(score_pts)
    );

    always #5 frame_clk = ~frame_clk;

    // ---------------- behavioural model ----------------
    int m_phase, m_elapsed, m_k, m_combo, m_pts;
    bit m_fright, m_rev, m_sv;

    function automatic int dur(input int p);
        case (p)
            0, 2:    return SCAT;
            4, 6:    return LATE;
            default: return CHASE;
        endcase
    endfunction

    function automatic int exp_mode();
        return m_fright ? 2 : (m_phase % 2);
    endfunction

    // Flash from frames remaining in fright: high for the first PERIOD frames of the window, then alternating.
    function automatic int exp_flash();
        int r;
        if (!m_fright) return 0;
        r = FRIGHT - 1 - m_k;
        if (r >= FLASH) return 0;
        return (((FLASH - 1 - r) / PERIOD) % 2 == 0) ? 1 : 0;
    endfunction

    always @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            m_phase = 0; m_elapsed = 0; m_k = 0; m_combo = 0; m_pts = 0;
            m_fright = 0; m_rev = 0; m_sv = 0;
        end else begin
            m_rev = 0;
            m_sv  = 0;
            if (enable) begin
                if (ghost_eaten && m_fright) begin
                    m_sv  = 1;
                    m_pts = 200 * (1 << m_combo);
                    if (m_combo < 3) m_combo++;
                end
                if (m_fright) begin
                    if (power_pellet) begin
                        m_k = 0; m_combo = 0;
                    end else if (m_k == FRIGHT - 1) begin
                        m_fright = 0;
                    end else begin
                        m_k++;
                    end
                end else begin
                    if (m_phase < 7) begin
                        m_elapsed++;
                        if (m_elapsed == dur(m_phase)) begin
                            m_phase++; m_elapsed = 0; m_rev = 1;
                        end
                    end
                    if (power_pellet) begin
                        m_fright = 1; m_k = 0; m_combo = 0; m_rev = 1;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every frame against the model, away from the active edge.
    always @(negedge frame_clk) begin
        if (cmp_en && !Reset) begin
            check("mode", int'(mode), exp_mode());
            check("phase", int'(phase), m_phase);
            check("flash", int'(flash), exp_flash());
            check("reverse", int'(reverse), int'(m_rev));
            check("score_valid", int'(score_valid), int'(m_sv));
            check("score_pts", int'(score_pts), m_pts);
        end
    end

    // One frame: optional async reset pulse, present inputs, take one edge, return 2 ns after it.
    task automatic frame(input bit pp, input bit ge, input bit en, input bit rst = 1'b0);
        if (rst) begin
            Reset = 1'b1; #1; Reset = 1'b0;
        end
        power_pellet = pp;
        ghost_eaten  = ge;
        enable       = en;
        @(posedge frame_clk);
        #2;
        power_pellet = 1'b0;
        ghost_eaten  = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mode"}, int'(mode), 0);
        check({tag, "_phase"}, int'(phase), 0);
        check({tag, "_flash"}, int'(flash), 0);
        check({tag, "_reverse"}, int'(reverse), 0);
        check({tag, "_score_valid"}, int'(score_valid), 0);
        check({tag, "_score_pts"}, int'(score_pts), 0);
    endtask

    initial begin
        int seq[$];
        int durs[7];
        int revs;
        int p;
        int flash_exp[8];
        int pts_exp[5];
        durs      = '{4, 6, 4, 6, 3, 6, 3};
        flash_exp = '{0, 0, 0, 0, 1, 1, 0, 0};
        pts_exp   = '{200, 400, 800, 1600, 1600};

        #1 Reset = 1'b1;
        #20;
        check_reset_values("reset");
        #3 Reset = 1'b0;
        @(posedge frame_clk);
        #2;
        cmp_en = 1'b1;

        // Free run through the whole schedule.
        for (int i = 0; i < 7; i++)
            for (int j = 0; j < durs[i]; j++) seq.push_back(i % 2);
        check("free_mode_0", int'(mode), seq[0]);
        revs = 0;
        for (int j = 1; j < 40; j++) begin
            frame(0, 0, 1);
            if (reverse) revs++;
            check("free_mode", int'(mode), (j < seq.size()) ? seq[j] : 1);
        end
        check("free_reverse_count", revs, 7);
        check("free_phase_final", int'(phase), 7);

        // Async reset between edges.
        #1 Reset = 1'b1;
        #1;
        check_reset_values("async_reset");
        Reset = 1'b0;

        // Pellet during the second frame of phase 0.
        frame(0, 0, 1);
        frame(1, 0, 1);
        check("entry_mode", int'(mode), 2);
        check("entry_reverse", int'(reverse), 1);
        check("entry_flash", int'(flash), flash_exp[0]);
        for (int i = 1; i < 8; i++) begin
            frame(0, 0, 1);
            check("fright_flash", int'(flash), flash_exp[i]);
            check("fright_mode", int'(mode), 2);
        end
        frame(0, 0, 1);
        check("expire_mode", int'(mode), 0);
        check("expire_reverse", int'(reverse), 0);
        frame(0, 0, 1);
        check("resume_phase0", int'(phase), 0);
        frame(0, 0, 1);
        check("resume_phase1", int'(phase), 1);
        check("resume_reverse", int'(reverse), 1);

        // Combo and out-of-fright eaten pulse.
        frame(0, 1, 1);
        check("eaten_outside", int'(score_valid), 0);
        frame(1, 0, 1);
        for (int i = 0; i < 5; i++) begin
            frame(0, 1, 1);
            check("combo_valid", int'(score_valid), 1);
            check("combo_pts", int'(score_pts), pts_exp[i]);
        end
        check("retrig_flash_before", int'(flash), 1);
        frame(1, 0, 1);
        check("retrig_mode", int'(mode), 2);
        check("retrig_reverse", int'(reverse), 0);
        check("retrig_flash", int'(flash), 0);
        frame(0, 1, 1);
        check("retrig_pts", int'(score_pts), 200);
        frame(0, 1, 1);
        check("combo2_pts", int'(score_pts), 400);
        frame(1, 1, 1);
        check("pellet_eaten_pts", int'(score_pts), 800);
        frame(0, 1, 1);
        check("after_pellet_eaten_pts", int'(score_pts), 200);

        // Pellet on the expiry edge: fright counter is now at 6, 6 more frames reach 0.
        for (int i = 0; i < 6; i++) frame(0, 0, 1);
        frame(1, 0, 1);
        check("expiry_pellet_mode", int'(mode), 2);
        check("expiry_pellet_reverse", int'(reverse), 0);

        // Enable low mid-fright with a pellet presented.
        frame(0, 0, 1);
        frame(0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            frame(i == 2, 0, 0);
            check("hold_mode", int'(mode), 2);
            check("hold_reverse", int'(reverse), 0);
        end
        begin
            int n = 0;
            while (m_fright && n < 20) begin frame(0, 0, 1); n++; end
            check("fright_end_timeout", int'(m_fright), 0);
        end

        // Pellet exactly on a schedule boundary.
        begin
            int n = 0;
            while (!(m_phase < 7 && m_elapsed == dur(m_phase) - 1) && n < 40) begin
                frame(0, 0, 1); n++;
            end
            check("boundary_search_timeout", int'(m_phase < 7 && m_elapsed == dur(m_phase) - 1), 1);
            p = m_phase;
            revs = 0;
            frame(1, 0, 1);
            if (reverse) revs++;
            check("boundary_phase", int'(phase), p + 1);
            check("boundary_mode", int'(mode), 2);
            frame(0, 0, 1);
            if (reverse) revs++;
            check("boundary_reverse_count", revs, 1);
        end

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            frame($urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 9) != 0, $urandom_range(0, 299) == 0);
        end

        @(negedge frame_clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ghost_mode_scheduler.md
# ghost_mode_scheduler

Frame-rate controller that sequences the global ghost behaviour mode (scatter, chase, frightened) for all four ghost blocks. It runs the fixed scatter/chase phase schedule, the power-pellet frightened timer with end-of-fright flashing, and the direction-reversal strobe. It also runs the eaten-ghost score combo. It sits between the game-state logic (pellet and collision events) and the ghost movement blocks, which consume `mode`, `reverse` and `flash`.

## Interface
Parameters:
- `SCATTER_FRAMES`, 420: duration of phases 0 and 2.
- `SCATTER_LATE_FRAMES`, 300: duration of phases 4 and 6.
- `CHASE_FRAMES`, 1200: duration of phases 1, 3 and 5. Phase 7 is unbounded.
- `FRIGHT_FRAMES`, 360: frightened duration. Must be ≥ 2.
- `FLASH_FRAMES`, 120: length of the flashing window at the end of fright. Must be < `FRIGHT_FRAMES`.
- `FLASH_PERIOD`, 14: frames per flash half-cycle. Must be ≥ 1.

Ports:
- `frame_clk`, in, 1: the single clock; one edge per video frame.
- `Reset`, in, 1: asynchronous, active-high.
- `enable`, in, 1: game running. When low, all state holds and input events are ignored.
- `power_pellet`, in, 1: one-frame pulse; a power pellet was eaten.
- `ghost_eaten`, in, 1: one-frame pulse; Pac-Man collided with a frightened ghost.
- `mode`, out, 2: 00 = scatter, 01 = chase, 10 = frightened. 11 never driven.
- `phase`, out, 3: current schedule phase, 0–7.
- `flash`, out, 1: ghosts draw the flashing (white) sprite.
- `reverse`, out, 1: one-frame strobe; all ghosts reverse direction.
- `score_valid`, out, 1: one-frame strobe accompanying `score_pts`.
- `score_pts`, out, 11: points for the eaten ghost (200/400/800/1600).

## Operation
- Reset values:
  - `mode` = 00, `phase` = 0.
  - `flash`, `reverse`, `score_valid` = 0; `score_pts` = 0.
  - Internal state: schedule counter = 0, fright counter = 0, flash counter = 0, combo = 0.
- Schedule:
  - Even phases are scatter; odd phases are chase.
  - Each enabled frame outside fright increments the 11-bit schedule counter.
  - When the counter equals (phase duration − 1): `phase` increments, the counter clears, and `reverse` pulses.
  - In phase 7 the counter stops and the phase never advances.
- Frightened entry: `power_pellet` while enabled and `mode` ≠ 10 does the following:
  - `mode` becomes 10 and the fright counter loads `FRIGHT_FRAMES` − 1.
  - combo clears, `flash` clears, and `reverse` pulses.
  - The schedule counter and `phase` freeze for the whole fright.
- Re-trigger: `power_pellet` while `mode` = 10 reloads the fright counter, clears combo, and clears `flash` and the flash counter. No reverse.
- Fright countdown:
  - The fright counter decrements each enabled frame.
  - When it is 0 at an edge, `mode` returns to the mode implied by `phase`, `flash` clears, and no reverse is issued.
  - The schedule resumes from its frozen count.
- Flash:
  - On the edge where the fright counter loads `FLASH_FRAMES` − 1, `flash` goes high and the flash counter clears.
  - After that, `flash` toggles every `FLASH_PERIOD` frames until fright ends.
- Score:
  - `ghost_eaten` while `mode` = 10 produces, next edge, `score_valid` = 1 and `score_pts` = 200 << combo.
  - Combo then increments, saturating at 3.
  - `ghost_eaten` outside fright is ignored. `score_pts` holds its last value between strobes.
- Simultaneous events:
  - `power_pellet` + `ghost_eaten` in fright: the ghost is scored with the old combo, then combo clears.
  - `power_pellet` + schedule boundary: the phase still advances, `mode` = 10, exactly one `reverse` pulse.
  - `power_pellet` on the fright-expiry edge: the re-trigger wins, `mode` stays 10, no reverse.
- `enable` low: counters, `mode`, `phase` and `flash` hold. Strobes drop to 0. Events presented during that time are lost.
- `Reset` mid-fright or mid-phase: immediate return to the reset values.

## Timing
- All outputs are registered on posedge `frame_clk`. Latency from an input event to its output effect is one edge.
- Strobes (`reverse`, `score_valid`) are high for exactly one frame and never back-to-back from a single event.
- Phase n lasts exactly its duration in enabled, non-frightened frames.
- Fright lasts exactly `FRIGHT_FRAMES` enabled frames from the entry edge to the return edge.

## Test plan
All scenarios use SCATTER=4, SCATTER_LATE=3, CHASE=6, FRIGHT=8, FLASH_FRAMES=4, FLASH_PERIOD=2.

- **Reset then free-run.** Release reset, enable held high → `mode` sequence 00×4, 01×6, 00×4, 01×6, 00×3, 01×6, 00×3, then 01 forever. `reverse` pulses once at each of the 7 transitions. `phase` stops at 7.
- **Pellet at frame 2 of phase 0.**
  - Next edge: `mode` = 10 with a `reverse` pulse.
  - 8 frames later: `mode` = 00 without reverse.
  - Phase 0 then lasts 2 more frames.
  - `flash` is high for the last 4 fright frames, pattern 1,1,0,0.
- **Ghost combo.** 5 `ghost_eaten` pulses in fright → `score_pts` 200, 400, 800, 1600, 1600, each with one `score_valid`. An eaten pulse outside fright → no strobe.
- **Re-trigger.** Pellet at fright counter = 2, while `flash` is high → counter reloads to 7, `flash` = 0, combo = 0, no `reverse`. Next eaten ghost scores 200.
- **Collisions.**
  - Pellet on a schedule boundary → one `reverse` and `phase` increments.
  - Pellet on the expiry edge → `mode` stays 10.
  - Pellet + eaten ghost with combo = 2 → 800 scored, next eaten ghost scores 200.
- **Enable and async reset.** `enable` low for 5 frames mid-fright → counters hold and the pellet pulse is ignored. Asynchronous `Reset` pulse between edges → outputs return to the reset values immediately.
